// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL bring-up / system reset sequencer.
// Holds the sequencer state encoding, retry counter sizing and a counter-width helper.
package pll_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   localparam int                 RETRY_W   = 4;
   localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;

   // Width of a counter that runs from 0 up to max_count-1.
   function automatic int cnt_w(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_button_debouncer.sv
// Two-flop synchronizer followed by a stable-count filter for a raw push button.
// The filtered output follows the synchronized input only after DebounceCycles disagreeing cycles.
module button_debouncer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int   DebounceCycles = 120000,
   parameter logic ResetVal       = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic db
);

   localparam int              CntW    = cnt_w(DebounceCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic            meta;
   logic            sync;
   logic [CntW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= ResetVal;
         sync <= ResetVal;
         db   <= ResetVal;
         cnt  <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         // Any cycle of agreement restarts the filter.
         if (sync == db) begin
            cnt <= '0;
         end else if (cnt == CntLast) begin
            db  <= sync;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences SB_PLL40 reset/lock on the reference clock and gates the downstream system reset.
// Outputs are registered from the next state so they move on the same edge as state_o.
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int PllResetCycles    = 16,
   parameter int LockTimeoutCycles = 1200000,
   parameter int LockStableCycles  = 1024,
   parameter int DebounceCycles    = 120000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pll_lock_i,
   input  logic               btn_ni,
   output logic               pll_resetb_o,
   output logic               sys_rst_no,
   output logic [1:0]         state_o,
   output logic [RETRY_W-1:0] retry_count_o,
   output logic               lock_lost_o
);

   localparam int              CntW       = cnt_w(max3(PllResetCycles, LockTimeoutCycles,
                                                       LockStableCycles));
   localparam logic [CntW-1:0] RstLast    = CntW'(PllResetCycles - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LockTimeoutCycles - 1);
   localparam logic [CntW-1:0] StableLast = CntW'(LockStableCycles - 1);

   seq_state_t         state;
   seq_state_t         state_next;
   logic [CntW-1:0]    cnt;
   logic [CntW-1:0]    cnt_next;
   logic [RETRY_W-1:0] retry_next;
   logic               pll_resetb_next;
   logic               sys_rst_next;
   logic               lock_lost_next;

   logic lock_meta;
   logic lock_s;
   logic btn_db;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock_i;
         lock_s    <= lock_meta;
      end
   end

   button_debouncer #(
      .DebounceCycles (DebounceCycles),
      .ResetVal       (1'b1)
   ) u_btn_db (
      .clk (clk_i),
      .rst (rst_i),
      .raw (btn_ni),
      .db  (btn_db)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= PLL_RST;
         cnt           <= '0;
         retry_count_o <= '0;
         pll_resetb_o  <= 1'b0;
         sys_rst_no    <= 1'b0;
         lock_lost_o   <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         retry_count_o <= retry_next;
         pll_resetb_o  <= pll_resetb_next;
         sys_rst_no    <= sys_rst_next;
         lock_lost_o   <= lock_lost_next;
      end
   end

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      retry_next     = retry_count_o;
      lock_lost_next = 1'b0;

      case (state)
         PLL_RST: begin
            if (cnt == RstLast) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         WAIT_LOCK: begin
            // Lock takes priority over a timeout landing on the same cycle.
            if (lock_s) begin
               state_next = STABLE;
               cnt_next   = '0;
            end else if (cnt == TimeoutLast) begin
               state_next = PLL_RST;
               cnt_next   = '0;
               if (retry_count_o != RETRY_MAX) begin
                  retry_next = retry_count_o + 1'b1;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt == StableLast) begin
               state_next = RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_next     = PLL_RST;
               cnt_next       = '0;
               lock_lost_next = 1'b1;
            end
         end
         default: begin
            state_next = PLL_RST;
            cnt_next   = '0;
         end
      endcase

      pll_resetb_next = (state_next != PLL_RST);
      sys_rst_next    = (state_next == RUN) && btn_db;
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed, table-driven bench for pll_reset_sequencer with small sequencing parameters.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lock = 1'b0;
   logic       btn = 1'b1;
   logic       pll_resetb;
   logic       sys_rst_n;
   logic [1:0] state;
   logic [3:0] retry;
   logic       lock_lost;

   int checks = 0;
   int errors = 0;

   pll_reset_sequencer #(
      .PllResetCycles    (4),
      .LockTimeoutCycles (20),
      .LockStableCycles  (8),
      .DebounceCycles    (5)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pll_lock_i    (lock),
      .btn_ni        (btn),
      .pll_resetb_o  (pll_resetb),
      .sys_rst_no    (sys_rst_n),
      .state_o       (state),
      .retry_count_o (retry),
      .lock_lost_o   (lock_lost)
   );

   always #5 clk = ~clk;

   // n cycles with the given inputs; outputs checked after every rising edge.
   typedef struct {
      int         n;
      logic       lock;
      logic       btn;
      logic [1:0] st;
      logic       rb;
      logic       sr;
      logic [3:0] rt;
      logic       ll;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(int n, int lk, int bt, int st, int rb, int sr, int rt, int ll);
      vec_t r;
      r.n    = n;
      r.lock = lk[0];
      r.btn  = bt[0];
      r.st   = st[1:0];
      r.rb   = rb[0];
      r.sr   = sr[0];
      r.rt   = rt[3:0];
      r.ll   = ll[0];
      return r;
   endfunction

   task automatic chk(input string tag, input string name, input logic [3:0] act,
                      input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t r);
      chk(tag, "state", {2'b00, state}, {2'b00, r.st});
      chk(tag, "pll_resetb", {3'b000, pll_resetb}, {3'b000, r.rb});
      chk(tag, "sys_rst_n", {3'b000, sys_rst_n}, {3'b000, r.sr});
      chk(tag, "retry", retry, r.rt);
      chk(tag, "lock_lost", {3'b000, lock_lost}, {3'b000, r.ll});
   endtask

   task automatic run_vec(input string tag, input vec_t r);
      for (int i = 0; i < r.n; i++) begin
         lock = r.lock;
         btn  = r.btn;
         @(posedge clk);
         @(negedge clk);
         chk_all($sformatf("%s.%0d", tag, i), r);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      lock = 1'b0;
      btn  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int sat(int k);
      return (k > 15) ? 15 : k;
   endfunction

   initial begin
      // Bring-up, debounce in RUN, lock loss, lock glitch in STABLE
      tab.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(4, 0, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(2, 1, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(8, 1, 1, 2, 1, 0, 0, 0));
      tab.push_back(mk(4, 1, 1, 3, 1, 1, 0, 0));
      tab.push_back(mk(3, 1, 0, 3, 1, 1, 0, 0));
      tab.push_back(mk(3, 1, 1, 3, 1, 1, 0, 0));
      tab.push_back(mk(4, 1, 0, 3, 1, 1, 0, 0));
      tab.push_back(mk(3, 1, 1, 3, 1, 1, 0, 0));
      tab.push_back(mk(7, 1, 0, 3, 1, 1, 0, 0));
      tab.push_back(mk(3, 1, 0, 3, 1, 0, 0, 0));
      tab.push_back(mk(7, 1, 1, 3, 1, 0, 0, 0));
      tab.push_back(mk(3, 1, 1, 3, 1, 1, 0, 0));
      tab.push_back(mk(2, 0, 1, 3, 1, 1, 0, 0));
      tab.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));
      tab.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(2, 1, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(4, 1, 1, 2, 1, 0, 0, 0));
      tab.push_back(mk(1, 0, 1, 2, 1, 0, 0, 0));
      tab.push_back(mk(1, 1, 1, 2, 1, 0, 0, 0));
      tab.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0));
      tab.push_back(mk(8, 1, 1, 2, 1, 0, 0, 0));
      tab.push_back(mk(2, 1, 1, 3, 1, 1, 0, 0));

      // Reset state while rst is held
      @(negedge clk);
      chk_all("reset", mk(1, 0, 1, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tab.size(); i++) begin
         run_vec($sformatf("row%0d", i), tab[i]);
      end

      // Lock timeouts with retry saturation
      do_reset();
      run_vec("sat_init", mk(3, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 17; k++) begin
         run_vec($sformatf("sat_wait%0d", k), mk(20, 0, 1, 1, 1, 0, sat(k - 1), 0));
         run_vec($sformatf("sat_rst%0d", k), mk(4, 0, 1, 0, 0, 0, sat(k), 0));
      end

      // Three retries, lock arriving on the timeout cycle, then async reset in STABLE
      do_reset();
      run_vec("r3_init", mk(3, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 3; k++) begin
         run_vec($sformatf("r3_wait%0d", k), mk(20, 0, 1, 1, 1, 0, k - 1, 0));
         run_vec($sformatf("r3_rst%0d", k), mk(4, 0, 1, 0, 0, 0, k, 0));
      end
      run_vec("tmo_wait", mk(18, 0, 1, 1, 1, 0, 3, 0));
      run_vec("tmo_lock", mk(2, 1, 1, 1, 1, 0, 3, 0));
      run_vec("tmo_stable", mk(3, 1, 1, 2, 1, 0, 3, 0));
      rst = 1'b1;
      #1;
      chk_all("async_rst", mk(1, 1, 1, 0, 0, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      chk_all("async_hold", mk(1, 1, 1, 0, 0, 0, 0, 0));
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
